// File: rtl/predictor_update_ctrl_if.sv
// Commit-side update channel between the ROB and the predictor update controller.
// The ROB offers a resolved branch; the controller reports when its queue is full.
interface predictor_update_ctrl_if;
  logic        rob_to_puc_valid;
  logic [31:0] rob_to_puc_PC;
  logic        rob_to_puc_br_taken;
  logic        puc_to_rob_full;

  modport master (
    output rob_to_puc_valid,
    output rob_to_puc_PC,
    output rob_to_puc_br_taken,
    input  puc_to_rob_full
  );

  modport slave (
    input  rob_to_puc_valid,
    input  rob_to_puc_PC,
    input  rob_to_puc_br_taken,
    output puc_to_rob_full
  );
endinterface

// File: rtl/predictor_update_ctrl.sv
// Predictor update controller: sweeps the table to weakly-taken after reset/flush,
// then drains queued commit updates in order. Optional statistics: PUC_STATS_EN.
module predictor_update_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int INDEX_W    = 7
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  predictor_update_ctrl_if.slave rob,
  output logic                   puc_to_pr_valid,
  output logic [INDEX_W-1:0]     puc_to_pr_index,
  output logic                   puc_to_pr_taken,
  output logic                   puc_to_pr_init,
  output logic                   puc_to_if_stall,
  output logic [15:0]            puc_stat_upd,
  output logic [15:0]            puc_stat_full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [INDEX_W-1:0] LAST_IDX = '1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] sweep_q, sweep_d;

  logic [INDEX_W-1:0] idx_mem [FIFO_DEPTH];
  logic               tkn_mem [FIFO_DEPTH];
  logic [PW-1:0]      rd_q, wr_q;
  logic [PW:0]        cnt_q;

  logic               full, empty, push, pop;
  logic               v_d, tkn_d, init_d;
  logic [INDEX_W-1:0] idx_d;

  // Full comes from registered occupancy only, so a same-cycle pop never frees a slot.
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign push  = rdy_in & rob.rob_to_puc_valid & ~full & ~flush_in;
  assign pop   = rdy_in & ~flush_in & (state_q == RUN) & ~empty;

  assign rob.puc_to_rob_full = full;
  assign puc_to_if_stall     = (state_q == INIT);

  // State and sweep counter register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next state and next predictor write: flush, sweep entry, or queued update.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    v_d     = 1'b0;
    idx_d   = '0;
    tkn_d   = 1'b0;
    init_d  = 1'b0;
    unique case (1'b1)
      flush_in: begin
        state_d = INIT;
        sweep_d = '0;
      end
      (!flush_in && state_q == INIT): begin
        v_d     = 1'b1;
        init_d  = 1'b1;
        idx_d   = sweep_q;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      pop: begin
        v_d   = 1'b1;
        idx_d = idx_mem[rd_q];
        tkn_d = tkn_mem[rd_q];
      end
      default: ;
    endcase
  end

  // Registered predictor write port.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      puc_to_pr_valid <= 1'b0;
      puc_to_pr_index <= '0;
      puc_to_pr_taken <= 1'b0;
      puc_to_pr_init  <= 1'b0;
    end else if (rdy_in) begin
      puc_to_pr_valid <= v_d;
      puc_to_pr_index <= idx_d;
      puc_to_pr_taken <= tkn_d;
      puc_to_pr_init  <= init_d;
    end
  end

  // Update queue: circular buffer, pointers wrap at the power-of-two depth.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        idx_mem[i] <= '0;
        tkn_mem[i] <= 1'b0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) begin
          idx_mem[wr_q] <= rob.rob_to_puc_PC[INDEX_W+1:2];
          tkn_mem[wr_q] <= rob.rob_to_puc_br_taken;
          wr_q          <= wr_q + 1'b1;
        end
        if (pop) begin
          rd_q <= rd_q + 1'b1;
        end
        unique case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef PUC_STATS_EN
  logic [15:0] upd_q, full_q;

  // Saturating counters; flush leaves them alone.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      upd_q  <= '0;
      full_q <= '0;
    end else begin
      if (push && upd_q != 16'hFFFF) begin
        upd_q <= upd_q + 1'b1;
      end
      if (rdy_in && full && full_q != 16'hFFFF) begin
        full_q <= full_q + 1'b1;
      end
    end
  end

  assign puc_stat_upd  = upd_q;
  assign puc_stat_full = full_q;
`else
  assign puc_stat_upd  = '0;
  assign puc_stat_full = '0;
`endif

endmodule
